// File: rtl/knn_sort_vote_if.sv
// Stream, vote and debug-readback signals of the KNN sort/vote stage.
// The master side is the distance core / register file; the slave side is the stage itself.
interface knn_sort_vote_if #(
    parameter int DIST_W  = 32,
    parameter int LABEL_W = 8,
    parameter int IDX_W   = 4
);
    logic               clear;
    logic               in_valid;
    logic               in_ready;
    logic [DIST_W-1:0]  in_dist;
    logic [LABEL_W-1:0] in_label;
    logic               classify;
    logic               busy;
    logic               out_valid;
    logic [LABEL_W-1:0] out_label;
    logic [IDX_W:0]     out_votes;
    logic [IDX_W:0]     fill;
    logic [IDX_W-1:0]   rd_idx;
    logic [DIST_W-1:0]  rd_dist;
    logic [LABEL_W-1:0] rd_label;

    modport master (
        output clear, in_valid, in_dist, in_label, classify, rd_idx,
        input  in_ready, busy, out_valid, out_label, out_votes, fill, rd_dist, rd_label
    );
    modport slave (
        input  clear, in_valid, in_dist, in_label, classify, rd_idx,
        output in_ready, busy, out_valid, out_label, out_votes, fill, rd_dist, rd_label
    );
endinterface

// File: rtl/knn_sort_vote.sv
// Keeps the K nearest (distance, label) pairs in ascending order and runs a
// sequential majority vote over them on request.
module knn_sort_vote #(
    parameter int K       = 4,
    parameter int DIST_W  = 32,
    parameter int LABEL_W = 8,
    parameter int IDX_W   = 4
) (
    input  logic            clk,
    input  logic            rst,
    knn_sort_vote_if.slave  bus
);
    localparam int CW = IDX_W + 1;

    typedef enum logic [1:0] {IDLE, VOTE, DONE} state_t;

    state_t             state_q, state_d;
    logic [DIST_W-1:0]  dist_q  [K];
    logic [DIST_W-1:0]  dist_d  [K];
    logic [LABEL_W-1:0] label_q [K];
    logic [LABEL_W-1:0] label_d [K];
    logic [CW-1:0]      fill_q, fill_d, n_q, n_d, best_cnt_q, best_cnt_d;
    logic [CW-1:0]      out_votes_q, out_votes_d;
    logic [IDX_W-1:0]   i_q, i_d;
    logic [LABEL_W-1:0] best_lab_q, best_lab_d, out_label_q, out_label_d;
    logic               busy_q, busy_d, out_valid_q, out_valid_d;

    logic               in_ready, take;
    logic [CW-1:0]      pos, cnt;
    logic [LABEL_W-1:0] cur_lab;

    assign in_ready = (state_q == IDLE) & ~bus.classify & ~bus.clear;
    assign take     = bus.in_valid & in_ready;

    // Insert position = number of stored entries not larger than the new one,
    // so equal distances land behind existing ones.
    always_comb begin
        pos = '0;
        for (int j = 0; j < K; j++)
            if (CW'(j) < fill_q && dist_q[j] <= bus.in_dist) pos = pos + CW'(1);
    end

    always_comb begin
        cur_lab = '0;
        for (int j = 0; j < K; j++)
            if (i_q == IDX_W'(j)) cur_lab = label_q[j];
        cnt = '0;
        for (int j = 0; j < K; j++)
            if (CW'(j) < n_q && label_q[j] == cur_lab) cnt = cnt + CW'(1);
    end

    always_comb begin
        state_d     = state_q;
        dist_d      = dist_q;
        label_d     = label_q;
        fill_d      = fill_q;
        n_d         = n_q;
        i_d         = i_q;
        best_cnt_d  = best_cnt_q;
        best_lab_d  = best_lab_q;
        out_label_d = out_label_q;
        out_votes_d = out_votes_q;
        busy_d      = busy_q;
        out_valid_d = 1'b0;

        if (take && pos < CW'(K)) begin
            for (int j = K - 1; j >= 1; j--)
                if (CW'(j) > pos) begin
                    dist_d[j]  = dist_q[j-1];
                    label_d[j] = label_q[j-1];
                end
            for (int j = 0; j < K; j++)
                if (CW'(j) == pos) begin
                    dist_d[j]  = bus.in_dist;
                    label_d[j] = bus.in_label;
                end
            fill_d = (fill_q == CW'(K)) ? fill_q : fill_q + CW'(1);
        end

        case (state_q)
            IDLE: if (bus.classify) begin
                n_d        = fill_q;
                i_d        = '0;
                best_cnt_d = '0;
                best_lab_d = '0;
                if (fill_q == '0) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_label_d = '0;
                    out_votes_d = '0;
                end else begin
                    state_d = VOTE;
                    busy_d  = 1'b1;
                end
            end
            VOTE: begin
                i_d = i_q + IDX_W'(1);
                // Strictly greater keeps the earliest (nearest) entry on ties.
                if (cnt > best_cnt_q) begin
                    best_cnt_d = cnt;
                    best_lab_d = cur_lab;
                end
                if ({1'b0, i_q} == n_q - CW'(1)) begin
                    state_d     = DONE;
                    busy_d      = 1'b0;
                    out_valid_d = 1'b1;
                    out_label_d = best_lab_d;
                    out_votes_d = best_cnt_d;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (bus.clear) begin
            state_d     = IDLE;
            fill_d      = '0;
            busy_d      = 1'b0;
            out_valid_d = 1'b0;
            out_label_d = '0;
            out_votes_d = '0;
            for (int j = 0; j < K; j++) begin
                dist_d[j]  = '1;
                label_d[j] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            fill_q      <= '0;
            n_q         <= '0;
            i_q         <= '0;
            best_cnt_q  <= '0;
            best_lab_q  <= '0;
            out_label_q <= '0;
            out_votes_q <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            for (int j = 0; j < K; j++) begin
                dist_q[j]  <= '1;
                label_q[j] <= '0;
            end
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            n_q         <= n_d;
            i_q         <= i_d;
            best_cnt_q  <= best_cnt_d;
            best_lab_q  <= best_lab_d;
            out_label_q <= out_label_d;
            out_votes_q <= out_votes_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            dist_q      <= dist_d;
            label_q     <= label_d;
        end
    end

    always_comb begin
        bus.rd_dist  = '0;
        bus.rd_label = '0;
        for (int j = 0; j < K; j++)
            if (bus.rd_idx == IDX_W'(j)) begin
                bus.rd_dist  = dist_q[j];
                bus.rd_label = label_q[j];
            end
    end

    assign bus.in_ready  = in_ready;
    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_label = out_label_q;
    assign bus.out_votes = out_votes_q;
    assign bus.fill      = fill_q;
endmodule

// File: tb/tb_knn_sort_vote.sv
// Directed bench for knn_sort_vote: sorted insertion, discard, vote, ties,
// empty vote, clear during a vote and asynchronous reset.
module tb_knn_sort_vote;
    localparam int K = 4, DIST_W = 32, LABEL_W = 8, IDX_W = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    knn_sort_vote_if #(.DIST_W(DIST_W), .LABEL_W(LABEL_W), .IDX_W(IDX_W)) bus ();
    knn_sort_vote #(.K(K), .DIST_W(DIST_W), .LABEL_W(LABEL_W), .IDX_W(IDX_W))
        dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ins(input logic [DIST_W-1:0] d, input logic [LABEL_W-1:0] l);
        bus.in_valid = 1'b1;
        bus.in_dist  = d;
        bus.in_label = l;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic entry(input logic [IDX_W-1:0] idx, input logic [DIST_W-1:0] d,
                         input logic [LABEL_W-1:0] l);
        bus.rd_idx = idx;
        #1;
        check($sformatf("rd_dist[%0d]", idx), 64'(bus.rd_dist), 64'(d));
        check($sformatf("rd_label[%0d]", idx), 64'(bus.rd_label), 64'(l));
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    // Pulse classify, expect n busy cycles then a one-cycle result.
    task automatic run_vote(input string tag, input int n,
                            input logic [LABEL_W-1:0] lab, input logic [IDX_W:0] votes);
        bus.classify = 1'b1;
        #1;
        check({tag, "_ready_on_classify"}, 64'(bus.in_ready), 0);
        tick();
        bus.classify = 1'b0;
        for (int k = 1; k <= n; k++) begin
            check($sformatf("%s_busy_c%0d", tag, k), 64'(bus.busy), 1);
            check($sformatf("%s_noval_c%0d", tag, k), 64'(bus.out_valid), 0);
            check($sformatf("%s_ready_c%0d", tag, k), 64'(bus.in_ready), 0);
            tick();
        end
        check({tag, "_out_valid"}, 64'(bus.out_valid), 1);
        check({tag, "_out_label"}, 64'(bus.out_label), 64'(lab));
        check({tag, "_out_votes"}, 64'(bus.out_votes), 64'(votes));
        check({tag, "_busy_done"}, 64'(bus.busy), 0);
        tick();
        check({tag, "_valid_pulse"}, 64'(bus.out_valid), 0);
        check({tag, "_label_held"}, 64'(bus.out_label), 64'(lab));
    endtask

    initial begin
        rst = 1'b1;
        bus.clear = 1'b0; bus.in_valid = 1'b0; bus.in_dist = '0; bus.in_label = '0;
        bus.classify = 1'b0; bus.rd_idx = '0;
        #12;
        check("rst_fill", 64'(bus.fill), 0);
        check("rst_busy", 64'(bus.busy), 0);
        check("rst_out_valid", 64'(bus.out_valid), 0);
        check("rst_out_label", 64'(bus.out_label), 0);
        check("rst_out_votes", 64'(bus.out_votes), 0);
        entry(0, 32'hFFFF_FFFF, 0);
        rst = 1'b0;
        tick();
        check("ready_after_rst", 64'(bus.in_ready), 1);

        ins(50, 1); ins(20, 2); ins(70, 1); ins(20, 3);
        check("fill_4", 64'(bus.fill), 4);
        entry(0, 20, 2); entry(1, 20, 3); entry(2, 50, 1); entry(3, 70, 1);

        ins(10, 3);
        bus.in_valid = 1'b1; bus.in_dist = 80; bus.in_label = 9;
        #1;
        check("ready_discard", 64'(bus.in_ready), 1);
        tick();
        bus.in_valid = 1'b0;
        check("fill_full", 64'(bus.fill), 4);
        entry(0, 10, 3); entry(1, 20, 2); entry(2, 20, 3); entry(3, 50, 1);
        entry(5, 0, 0);

        // Offer a pair throughout the vote; it must not be taken.
        bus.in_valid = 1'b1; bus.in_dist = 1; bus.in_label = 5;
        run_vote("vote4", 4, 3, 2);
        bus.in_valid = 1'b0;
        check("fill_after_vote", 64'(bus.fill), 4);
        entry(0, 10, 3);

        do_clear();
        check("clear_fill", 64'(bus.fill), 0);
        check("clear_label", 64'(bus.out_label), 0);
        ins(5, 7); ins(6, 4); ins(9, 4); ins(12, 7);
        run_vote("tie", 4, 7, 2);

        // Clear on vote cycle 2, also offering a pair that must be refused.
        bus.classify = 1'b1;
        tick();
        bus.classify = 1'b0;
        tick();
        bus.clear = 1'b1; bus.in_valid = 1'b1; bus.in_dist = 8; bus.in_label = 8;
        #1;
        check("ready_on_clear", 64'(bus.in_ready), 0);
        tick();
        bus.clear = 1'b0; bus.in_valid = 1'b0;
        check("abort_fill", 64'(bus.fill), 0);
        check("abort_busy", 64'(bus.busy), 0);
        check("abort_label", 64'(bus.out_label), 0);
        check("abort_votes", 64'(bus.out_votes), 0);
        entry(0, 32'hFFFF_FFFF, 0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("abort_noval_%0d", k), 64'(bus.out_valid), 0);
            tick();
        end

        run_vote("empty", 0, 0, 0);

        ins(1, 9);
        run_vote("single", 1, 9, 1);

        // Asynchronous reset in the middle of an insertion cycle.
        bus.in_valid = 1'b1; bus.in_dist = 2; bus.in_label = 2;
        #3;
        rst = 1'b1;
        #1;
        check("arst_fill", 64'(bus.fill), 0);
        check("arst_label", 64'(bus.out_label), 0);
        check("arst_votes", 64'(bus.out_votes), 0);
        check("arst_busy", 64'(bus.busy), 0);
        check("arst_valid", 64'(bus.out_valid), 0);
        bus.rd_idx = 0;
        #1;
        check("arst_rd_dist", 64'(bus.rd_dist), 64'(32'hFFFF_FFFF));
        bus.in_valid = 1'b0;
        #1;
        rst = 1'b0;
        tick();
        check("post_arst_fill", 64'(bus.fill), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
